// File: rtl/dm_pkg.sv
// Shared constants for the data-memory access controller: size codes, FSM encoding,
// byte-enable patterns and the alignment/lane helpers used by the top module.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  // op[OP_UNS] selects zero-extension on loads
  localparam int OP_UNS = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  // size code 2'b10 is illegal and always traps
  function automatic logic access_fault(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    return BE_B0 << lane;
      SZ_H:    return lane[1] ? BE_HI : BE_LO;
      default: return BE_ALL;
    endcase
  endfunction

endpackage

// File: rtl/ld_align.sv
// Load lane extraction: picks the addressed byte/half out of the memory word
// (little-endian) and sign- or zero-extends it to 32 bits.
module ld_align
  import dm_pkg::*;
(
  input  logic [31:0] dm_dout,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic        fill;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = dm_dout[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_b  = byte_lane[lane];
    sel_h  = lane[1] ? dm_dout[31:16] : dm_dout[15:0];
    fill   = 1'b0;
    result = dm_dout;
    case (op[1:0])
      SZ_B: begin
        fill   = ~op[OP_UNS] & sel_b[7];
        result = {{24{fill}}, sel_b};
      end
      SZ_H: begin
        fill   = ~op[OP_UNS] & sel_h[15];
        result = {{16{fill}}, sel_h};
      end
      default: result = dm_dout;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Multicycle load/store controller in front of dm_8k: registers the memory request,
// traps misaligned/illegal accesses, and captures the extended load result.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int DM_AW = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we_req,
  input  logic [2:0]       op,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [31:0]      rdata,
  output logic [DM_AW-1:0] dm_addr,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  logic [1:0]  state_reg;
  logic [2:0]  op_reg;
  logic [1:0]  lane_reg;
  logic [31:0] ld_result;

  ld_align u_ld_align (
    .dm_dout (dm_dout),
    .lane    (lane_reg),
    .op      (op_reg),
    .result  (ld_result)
  );

  // Pulses come straight from the state so an async reset kills them instantly
  assign busy = state_reg != ST_IDLE;
  assign done = (state_reg == ST_RESP) || (state_reg == ST_FAULT);
  assign err  = state_reg == ST_FAULT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      lane_reg  <= '0;
      err_addr  <= '0;
      rdata     <= '0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_din    <= '0;
      dm_we     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            if (access_fault(op[1:0], addr[1:0])) begin
              err_addr  <= addr;
              state_reg <= ST_FAULT;
            end else begin
              dm_addr   <= addr[DM_AW+1:2];
              dm_be     <= lane_be(op[1:0], addr[1:0]);
              dm_din    <= wdata;
              dm_we     <= we_req;
              op_reg    <= op;
              lane_reg  <= addr[1:0];
              state_reg <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // dm_we doubles as the store flag for this access
          if (!dm_we) rdata <= ld_result;
          dm_we     <= 1'b0;
          state_reg <= ST_RESP;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
